// File: rtl/aes_byte_sequencer_if.sv
// rtl/aes_byte_sequencer_if.sv - byte-stream, core and status bundle for the AES byte sequencer
interface aes_byte_sequencer_if #(
  parameter int NBYTES = 16
);
  logic                in_valid;
  logic                in_sel;
  logic [7:0]          in_data;
  logic                in_ready;
  logic [8*NBYTES-1:0] core_key;
  logic [8*NBYTES-1:0] core_pt;
  logic                core_start;
  logic                core_done;
  logic [8*NBYTES-1:0] core_ct;
  logic                out_valid;
  logic [7:0]          out_data;
  logic                out_ready;
  logic                key_loaded;
  logic                busy;
  logic                err;

  modport slave (
    input  in_valid, in_sel, in_data, core_done, core_ct, out_ready,
    output in_ready, core_key, core_pt, core_start, out_valid, out_data,
           key_loaded, busy, err
  );

  modport master (
    output in_valid, in_sel, in_data, core_done, core_ct, out_ready,
    input  in_ready, core_key, core_pt, core_start, out_valid, out_data,
           key_loaded, busy, err
  );
endinterface

// File: rtl/aes_byte_sequencer.sv
// rtl/aes_byte_sequencer.sv - assembles key/plaintext bytes for the AES core and streams the ciphertext back
module aes_byte_sequencer #(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  aes_byte_sequencer_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [CW-1:0] FULL      = CW'(NBYTES);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] key_cnt;
  logic [CW-1:0] pt_cnt;
  logic [CW-1:0] out_cnt;
  logic [TW-1:0] wait_cnt;
  logic [W-1:0]  key_reg;
  logic [W-1:0]  pt_reg;
  logic [W-1:0]  ct_buf;
  logic          key_loaded;
  logic          err;

  logic pt_full;
  logic in_fire;
  logic key_fire;
  logic pt_fire;
  logic out_fire;
  logic block_done;
  logic timeout_hit;
  logic in_ready_c;
  logic core_start_c;
  logic out_valid_c;
  logic busy_c;

  assign pt_full     = (pt_cnt == FULL);
  assign in_fire     = bus.in_valid & in_ready_c;
  assign key_fire    = in_fire & bus.in_sel;
  assign pt_fire     = in_fire & ~bus.in_sel;
  assign out_fire    = out_valid_c & bus.out_ready;
  assign block_done  = out_fire & (out_cnt == LAST_BYTE);
  // wait_cnt is the number of completed WAIT cycles, so abort on the last allowed one
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (pt_full && key_loaded) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          state_nxt = S_UNLOAD;
        end else if (timeout_hit) begin
          state_nxt = S_LOAD;
        end
      end
      S_UNLOAD: begin
        if (block_done) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // With a full plaintext buffer only key bytes may still enter, and only while the key is incomplete
  always_comb begin
    in_ready_c   = 1'b0;
    core_start_c = 1'b0;
    out_valid_c  = 1'b0;
    busy_c       = 1'b1;
    case (state)
      S_LOAD: begin
        busy_c     = 1'b0;
        in_ready_c = !pt_full || (bus.in_sel && !key_loaded);
      end
      S_START: begin
        core_start_c = 1'b1;
      end
      S_UNLOAD: begin
        out_valid_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt    <= '0;
      pt_cnt     <= '0;
      out_cnt    <= '0;
      wait_cnt   <= '0;
      key_reg    <= '0;
      pt_reg     <= '0;
      ct_buf     <= '0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (key_fire) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (key_cnt == CW'(i)) begin
            key_reg[W-1-8*i -: 8] <= bus.in_data;
          end
        end
        if (key_cnt == LAST_BYTE) begin
          key_cnt    <= '0;
          key_loaded <= 1'b1;
        end else begin
          key_cnt <= key_cnt + 1'b1;
          if (key_cnt == '0) begin
            key_loaded <= 1'b0;
          end
        end
      end

      if (pt_fire) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (pt_cnt == CW'(i)) begin
            pt_reg[W-1-8*i -: 8] <= bus.in_data;
          end
        end
        pt_cnt <= pt_cnt + 1'b1;
      end

      if (state == S_START) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (bus.core_done) begin
          ct_buf <= bus.core_ct;
          pt_cnt <= '0;
        end else if (timeout_hit) begin
          err    <= 1'b1;
          pt_cnt <= '0;
        end
      end

      // The buffer shifts towards the MSB so the outgoing byte is always the top one
      if (out_fire) begin
        ct_buf  <= ct_buf << 8;
        out_cnt <= block_done ? '0 : out_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.core_start = core_start_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.busy       = busy_c;
  assign bus.core_key   = key_reg;
  assign bus.core_pt    = pt_reg;
  assign bus.out_data   = ct_buf[W-1 -: 8];
  assign bus.key_loaded = key_loaded;
  assign bus.err        = err;
endmodule
